// File: rtl/uart_pkg.sv
// Shared UART receiver types: FSM state encoding, counter width and bit-period helper.
package uart_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned clock_freq,
                                               input int unsigned baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous pin; both flops reset to 1 (idle-high lines).
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_led.sv
// UART 8N1 receiver with mid-bit sampling; each good byte strobes rx_valid and lands on the LEDs.
// Define UART_RX_PARITY_EN to add an even-parity bit (11-bit frames) reported on parity_err.
module uart_rx_led
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 50000000,
  parameter int unsigned BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy,
  output logic [7:0] leds
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(HALF_BIT - 1);

  logic             rx_s;
  uart_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bad;
`else
  assign parity_err = 1'b0;
`endif

  // Receive FSM; status strobes default low so each lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      leds      <= '0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
      par_bad    <= 1'b0;
`endif
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      cnt <= cnt + CNT_W'(1);
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == H_LAST) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        DATA: begin
          if (cnt == C_LAST) begin
            cnt   <= '0;
            shift <= {rx_s, shift[7:1]};
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == C_LAST) begin
            cnt     <= '0;
            par_bad <= (^shift) ^ rx_s;
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (cnt == C_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
              parity_err <= par_bad;
              if (!par_bad) begin
`else
              begin
`endif
                rx_data  <= shift;
                leds     <= shift;
                rx_valid <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end
        end
        BREAK: begin
          // Held-low line: wait for idle before re-arming so a break is not read as a start.
          cnt <= '0;
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_led.sv
// Bench for uart_rx_led at C=16/H=8: directed timing cases plus randomized frames vs a frame-level model.
module tb_uart_rx_led;

  localparam int unsigned C = 16;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned NBITS  = 11;
  localparam bit          PAR_EN = 1'b1;
`else
  localparam int unsigned NBITS  = 10;
  localparam bit          PAR_EN = 1'b0;
`endif
  // Stop bit is checked at edge 3 + H + (NBITS-1)*C after the start bit is driven.
  localparam int unsigned STOP_AT = 3 + 8 + (NBITS - 1) * C;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;
  logic [7:0] leds;

  uart_rx_led #(
    .CLOCK_FREQ (16),
    .BAUD_RATE  (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy),
    .leds       (leds)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_cmp = 0;
  int          n_mis = 0;
  int          n_valid = 0;
  int          n_ferr = 0;
  int          n_perr = 0;
  int          n_viol = 0;
  int unsigned last_valid_cyc = 0;
  int unsigned last_ferr_cyc = 0;
  bit          prev_any = 1'b0;

  // Strobe monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid++;
      last_valid_cyc = cyc;
    end
    if (frame_err) begin
      n_ferr++;
      last_ferr_cyc = cyc;
    end
    if (parity_err) n_perr++;
    if ((int'(rx_valid) + int'(frame_err) + int'(parity_err)) > 1) n_viol++;
    if (prev_any && (rx_valid || frame_err || parity_err)) n_viol++;
    prev_any = rx_valid || frame_err || parity_err;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All drives happen 1 time unit after a rising edge.
  task automatic drive_bit(input logic v);
    rx = v;
    repeat (C) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_bit, input bit par,
                            output int unsigned e0);
    e0 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (PAR_EN) drive_bit(par);
    drive_bit(stop_bit);
  endtask

  int unsigned e0;
  int unsigned first_valid;
  int          nv0, nf0, np0;
  logic [7:0]  exp_leds;
  logic [7:0]  pb;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rx_data", 32'(rx_data), 32'h0);
    check_eq("rst_rx_valid", 32'(rx_valid), 32'h0);
    check_eq("rst_frame_err", 32'(frame_err), 32'h0);
    check_eq("rst_parity_err", 32'(parity_err), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_leds", 32'(leds), 32'h0);
    rst = 1'b1;
    idle(10);

    // Single 0xA5 frame, exact strobe timing
    nv0 = n_valid; nf0 = n_ferr;
    send_frame(8'hA5, 1'b1, ^8'hA5, e0);
    check_eq("a5_count", 32'(n_valid - nv0), 32'd1);
    check_eq("a5_timing", last_valid_cyc, e0 + STOP_AT);
    check_eq("a5_data", 32'(rx_data), 32'hA5);
    check_eq("a5_leds", 32'(leds), 32'hA5);
    check_eq("a5_ferr", 32'(n_ferr - nf0), 32'd0);
    check_eq("a5_valid_low", 32'(rx_valid), 32'h0);

    // Back-to-back 0x00 then 0xFF with no idle
    nv0 = n_valid;
    send_frame(8'h00, 1'b1, 1'b0, e0);
    first_valid = last_valid_cyc;
    check_eq("b2b_first_data", 32'(rx_data), 32'h00);
    send_frame(8'hFF, 1'b1, 1'b0, e0);
    check_eq("b2b_count", 32'(n_valid - nv0), 32'd2);
    check_eq("b2b_spacing", last_valid_cyc - first_valid, NBITS * C);
    check_eq("b2b_leds", 32'(leds), 32'hFF);

    // Start-bit glitch of 4 cycles
    idle(5);
    nv0 = n_valid; nf0 = n_ferr;
    e0 = cyc;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("glitch_busy_mid", 32'(busy), 32'h1);
    repeat (6) @(posedge clk);
    #1;
    check_eq("glitch_busy_end", 32'(busy), 32'h0);
    check_eq("glitch_at_cycle", cyc - e0, 32'd12);
    check_eq("glitch_valid", 32'(n_valid - nv0), 32'd0);
    check_eq("glitch_ferr", 32'(n_ferr - nf0), 32'd0);
    check_eq("glitch_leds", 32'(leds), 32'hFF);

    // Framing error then line held low
    idle(5);
    nv0 = n_valid; nf0 = n_ferr;
    send_frame(8'h3C, 1'b0, ^8'h3C, e0);
    repeat (40) @(posedge clk);
    #1;
    check_eq("ferr_count", 32'(n_ferr - nf0), 32'd1);
    check_eq("ferr_timing", last_ferr_cyc, e0 + STOP_AT);
    check_eq("ferr_valid", 32'(n_valid - nv0), 32'd0);
    check_eq("ferr_busy_held", 32'(busy), 32'h1);
    check_eq("ferr_leds", 32'(leds), 32'hFF);
    check_eq("ferr_data", 32'(rx_data), 32'hFF);
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("ferr_busy_release", 32'(busy), 32'h0);
    check_eq("ferr_count_after", 32'(n_ferr - nf0), 32'd1);

    // Reset during data bit 4 of 0x5A
    idle(10);
    pb = 8'h5A;
    nv0 = n_valid;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(pb[i]);
    rx = pb[4];
    repeat (5) @(posedge clk);
    #1;
    check_eq("midrst_busy_before", 32'(busy), 32'h1);
    rst = 1'b0;
    rx  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("midrst_rx_data", 32'(rx_data), 32'h0);
    check_eq("midrst_leds", 32'(leds), 32'h0);
    check_eq("midrst_busy", 32'(busy), 32'h0);
    check_eq("midrst_valid", 32'(rx_valid), 32'h0);
    check_eq("midrst_ferr", 32'(frame_err), 32'h0);
    rst = 1'b1;
    idle(20);
    check_eq("midrst_no_strobe", 32'(n_valid - nv0), 32'd0);
    send_frame(8'h81, 1'b1, ^8'h81, e0);
    check_eq("post_rst_count", 32'(n_valid - nv0), 32'd1);
    check_eq("post_rst_data", 32'(rx_data), 32'h81);
    check_eq("post_rst_leds", 32'(leds), 32'h81);
    exp_leds = 8'h81;

    // Parity directed: 0x07 has odd weight, so even parity bit is 1
    if (PAR_EN) begin
      idle(4);
      nv0 = n_valid; np0 = n_perr;
      send_frame(8'h07, 1'b1, 1'b1, e0);
      check_eq("par_ok_valid", 32'(n_valid - nv0), 32'd1);
      check_eq("par_ok_leds", 32'(leds), 32'h07);
      idle(4);
      nv0 = n_valid;
      send_frame(8'h07, 1'b1, 1'b0, e0);
      check_eq("par_bad_perr", 32'(n_perr - np0), 32'd1);
      check_eq("par_bad_valid", 32'(n_valid - nv0), 32'd0);
      check_eq("par_bad_leds", 32'(leds), 32'h07);
      exp_leds = 8'h07;
    end

    // Randomized frames against the frame-level model
    idle(4);
    for (int k = 0; k < 24; k++) begin
      logic [7:0] b;
      bit         s_ok;
      bit         p_ok;
      int         ev, ef, ep;
      b    = 8'($urandom);
      s_ok = ($urandom_range(0, 4) != 0);
      p_ok = ($urandom_range(0, 3) != 0);
      nv0 = n_valid; nf0 = n_ferr; np0 = n_perr;
      send_frame(b, s_ok, (^b) ^ !p_ok, e0);
      ev = 0; ef = 0; ep = 0;
      if (!s_ok) ef = 1;
      else if (PAR_EN && !p_ok) ep = 1;
      else begin
        ev = 1;
        exp_leds = b;
      end
      check_eq("rand_valid", 32'(n_valid - nv0), 32'(ev));
      check_eq("rand_ferr", 32'(n_ferr - nf0), 32'(ef));
      check_eq("rand_perr", 32'(n_perr - np0), 32'(ep));
      check_eq("rand_leds", 32'(leds), 32'(exp_leds));
      if (ev == 1) check_eq("rand_data", 32'(rx_data), 32'(b));
      if (!s_ok) begin
        repeat ($urandom_range(0, 20)) @(posedge clk);
        #1;
        idle(6 + int'($urandom_range(0, 4)));
      end else begin
        idle(int'($urandom_range(0, 3)));
      end
    end

    idle(10);
    check_eq("final_busy", 32'(busy), 32'h0);
    check_eq("strobe_exclusive", 32'(n_viol), 32'd0);
    if (!PAR_EN) check_eq("perr_tied_low", 32'(n_perr), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
